// File: rtl/en_strobe_pkg.sv
// rtl/en_strobe_pkg.sv - shared types and default widths for the enable-strobe generator
package en_strobe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } strobe_state_t;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_BURST_W = 8;

endpackage

// File: rtl/en_strobe_gen_if.sv
// rtl/en_strobe_gen_if.sv - control/status bundle between a requester and en_strobe_gen
interface en_strobe_gen_if
    import en_strobe_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) ();

    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   div;
    logic [BURST_W-1:0] burst_len;
    logic               en;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] pulses_sent;

    modport master (
        output start, abort, div, burst_len,
        input  en, busy, done, pulses_sent
    );

    modport slave (
        input  start, abort, div, burst_len,
        output en, busy, done, pulses_sent
    );

endinterface

// File: rtl/strobe_div_counter.sv
// rtl/strobe_div_counter.sv - modulo (limit+1) cycle counter with terminal-count flag
module strobe_div_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // tc marks the cycle in which the strobe should be issued
    assign tc = (cnt == limit);

    // Count 0..limit while running, wrapping to 0 on terminal count; clear has priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/en_strobe_gen.sv
// rtl/en_strobe_gen.sv - start/abort driven generator of periodic one-cycle enable strobes
module en_strobe_gen
    import en_strobe_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic           clk,
    input  logic           reset,
    en_strobe_gen_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]         state;
    logic [CNT_W-1:0]   div_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] pulses_q;
    logic [BURST_W-1:0] pulses_next;
    logic               en_q;
    logic               done_q;
    logic               tc;
    logic               cnt_run;
    logic               cnt_clear;

    // The counter only advances in RUN; it is held at zero otherwise so each run starts aligned
    assign cnt_run     = (state == ST_RUN);
    assign cnt_clear   = (state != ST_RUN) || bus.abort;
    assign pulses_next = pulses_q + 1'b1;

    assign bus.en          = en_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state == ST_RUN);
    assign bus.pulses_sent = pulses_q;

    strobe_div_counter #(
        .CNT_W (CNT_W)
    ) u_div_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .run   (cnt_run),
        .limit (div_q),
        .tc    (tc)
    );

    // Run-control FSM with registered strobe, done pulse and pulse counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            div_q    <= '0;
            len_q    <= '0;
            pulses_q <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    en_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        div_q    <= bus.div;
                        len_q    <= bus.burst_len;
                        pulses_q <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    done_q <= 1'b0;
                    if (bus.abort) begin
                        // abort beats a coincident strobe; pulses_sent is kept for inspection
                        en_q  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (tc) begin
                        en_q     <= 1'b1;
                        pulses_q <= pulses_next;
                        if ((len_q != '0) && (pulses_next == len_q)) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        en_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    en_q   <= 1'b0;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    en_q   <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
